uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  8N1 UART receiver; the receive end of the serial link driven by uart_tx. Synchronises rx,
//  validates the start bit, samples at bit centre, holds one byte for the CPU bus slave port.
//  Reports framing/overrun errors and pulses o_int when a byte is stored.
// PARAMETERS
//  SYS_CLK   50_000_000  system clock in Hz
//  BAUDRATE  115200      line rate in baud
//  TICK      SYS_CLK/BAUDRATE = 434 (localparam)  clocks per bit
//  HALF      TICK/2 = 217 (localparam)             clocks to bit centre
// PORTS
//  i_clk      in   1  system clock, rising edge
//  i_reset_n  in   1  asynchronous reset, active low
//  i_adr      in   1  register select: 0 = DATA, 1 = STATUS
//  i_dat      in   8  write data; writes are ignored, no register is writable
//  o_dat      out  8  read data: DATA -> rx_data; STATUS -> {4'b0, active, overrun, frame_err, valid}
//  i_we       in   1  write strobe
//  i_cyc      in   1  bus cycle; read = i_cyc & ~i_we
//  rx         in   1  asynchronous serial input, idle high
//  o_int      out  1  one-cycle pulse when a byte is stored in rx_data
// BEHAVIOUR
//  - Reset: state IDLE, synchroniser flops = 1, rx_data = 0, valid/frame_err/overrun = 0, o_int = 0.
//  - rx passes through a 2-flop synchroniser; rx_s is the synchronised bit. All logic uses rx_s.
//  - Bit counter: 9-bit, cleared on entering START and on every bit tick; tick = (cnt == TICK-1).
//  - FSM: IDLE -> START when rx_s == 0. Counter cleared.
//    START: at cnt == HALF-1, if rx_s == 0 -> DATA (counter cleared, bit index 0); else -> IDLE (glitch).
//    DATA: on each tick sample rx_s into shift reg, LSB first; after bit 7 -> STOP.
//    STOP: on tick sample rx_s. If 1 -> store. If 0 -> frame_err <= 1, byte discarded.
//    Both cases -> IDLE.
//    IDLE re-arms on the next low rx_s. A continuous break (rx low) gives repeated frame errors.
//  - Store: if valid == 0, or a DATA read happens the same cycle: rx_data <= shift, valid <= 1, o_int <= 1.
//    Otherwise overrun <= 1; new byte discarded, rx_data kept, no o_int.
//  - DATA read (i_cyc & ~i_we & ~i_adr): o_dat = rx_data combinationally; valid <= 0 next edge.
//  - STATUS read (i_cyc & ~i_we & i_adr): o_dat combinational; frame_err and overrun <= 0 next edge.
//    An error set in the same cycle as the read wins (flag stays 1).
//  - active = (state != IDLE).
//  - o_int is registered: high exactly one cycle, in the cycle after the store decision.
//  - Latency: store occurs HALF + 9*TICK clocks after the first low rx_s (+2 for the synchroniser).
//  - Reset mid-frame aborts immediately; no partial byte is stored.
//  - Continuous reads hold nothing off; reception never stalls on the bus.
// STRUCTURE
//  - Shared include uart_defs.vh (also used by uart_tx):
//    TICK derivation, STATUS bit positions (VALID=0, FERR=1, OVR=2, ACTIVE=3), FSM state encodings.
//  - Sub-module uart_rx_sync: 2-flop synchroniser, async active-low reset to 1, parameterless.
//  - FSM, counter, shift register and bus regs stay in uart_rx.
// TESTING (TICK = 434; loop rx from a uart_tx instance and also drive rx directly from a BFM)
//  1. Send 0xA5 -> o_int one cycle; STATUS = 0x01; DATA read = 0xA5; STATUS afterwards = 0x00.
//  2. rx low for 100 clocks then high -> FSM returns to IDLE; no o_int; STATUS = 0x00.
//  3. Send 0x3C with stop bit = 0 -> no o_int; STATUS = 0x02; STATUS read clears it to 0x00.
//  4. Send 0x11 then 0x22 without reading -> one o_int; STATUS = 0x05; DATA = 0x11.
//  5. Send 0x55; DATA read lands exactly on the store cycle of the next byte 0x66 ->
//     valid stays 1, overrun 0, DATA = 0x66.
//  6. Assert i_reset_n low mid-DATA of 0xFF; release; send 0x0F ->
//     STATUS = 0x01; DATA = 0x0F; no residue from the aborted frame.
//  7. Baud tolerance: BFM bit period 434±2% -> 0x5A received correctly; frame_err stays 0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
//   Shared definitions for the 8N1 UART receiver:
//     - FSM state encodings (2-bit, legacy-compatible constants)
//     - STATUS register bit positions
//     - clocks_per_bit(): bit period in system clocks
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  // Receiver FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // STATUS register bit positions (upper nibble reads as zero)
  localparam int STAT_VALID  = 0;
  localparam int STAT_FERR   = 1;
  localparam int STAT_OVR    = 2;
  localparam int STAT_ACTIVE = 3;

  // Integer clocks per bit; truncation matches the integer divide of the
  // transmitter so both ends agree on the bit period.
  function automatic int clocks_per_bit(input int sys_clk, input int baud);
    return sys_clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchroniser for the asynchronous serial input. Both flops reset
//   to 1 so that the idle-high line does not look like a start bit after reset.
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous reset, active low
//   d      in  1  asynchronous input
//   q      out 1  synchronised output
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver with a one-byte holding register on a small CPU bus
//   slave port. Start bit is re-checked at its centre, data bits are sampled
//   at bit centre LSB first, and the stop bit decides store vs framing error.
// Ports:
//   i_clk      in   1  system clock, rising edge
//   i_reset_n  in   1  asynchronous reset, active low
//   i_adr      in   1  register select: 0 = DATA, 1 = STATUS
//   i_dat      in   8  write data (no writable registers; ignored)
//   o_dat      out  8  read data: DATA -> rx_data, STATUS -> {4'b0, active,
//                      overrun, frame_err, valid}
//   i_we       in   1  write strobe
//   i_cyc      in   1  bus cycle; a read is i_cyc & ~i_we
//   rx         in   1  asynchronous serial input, idle high
//   o_int      out  1  one-cycle pulse when a byte is stored in rx_data
// -----------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int SYS_CLK  = 50_000_000,
  parameter int BAUDRATE = 115200
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_adr,
  input  logic [7:0] i_dat,
  output logic [7:0] o_dat,
  input  logic       i_we,
  input  logic       i_cyc,
  input  logic       rx,
  output logic       o_int
);

  localparam int TICK = clocks_per_bit(SYS_CLK, BAUDRATE);
  localparam int HALF = TICK / 2;
  localparam logic [8:0] TICK_LAST = 9'(TICK - 1);
  localparam logic [8:0] HALF_LAST = 9'(HALF - 1);

  logic       rx_s;
  logic [1:0] state_reg;
  logic [8:0] cnt_reg;
  logic [2:0] bit_idx_reg;
  logic [7:0] shift_reg;

  logic [7:0] rx_data_reg;
  logic       valid_reg;
  logic       frame_err_reg;
  logic       overrun_reg;
  logic       int_reg;

  logic       tick;
  logic       stop_tick;
  logic       store_evt;
  logic       frame_evt;
  logic       accept;
  logic       ovr_evt;
  logic       data_rd;
  logic       status_rd;
  logic [3:0] status;
  logic       unused_wdat;

  // The bus has no writable register; the write data is intentionally dropped.
  assign unused_wdat = ^i_dat;

  uart_rx_sync u_sync (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign tick      = (cnt_reg == TICK_LAST);
  assign stop_tick = (state_reg == ST_STOP) && tick;
  assign store_evt = stop_tick && rx_s;
  assign frame_evt = stop_tick && !rx_s;
  assign data_rd   = i_cyc && !i_we && !i_adr;
  assign status_rd = i_cyc && !i_we && i_adr;
  // A DATA read in the store cycle frees the holding register just in time,
  // so the new byte is accepted rather than flagged as an overrun.
  assign accept    = store_evt && (!valid_reg || data_rd);
  assign ovr_evt   = store_evt && !accept;

  // Receiver FSM, bit counter and shift register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (!rx_s) state_reg <= ST_START;
        end
        ST_START: begin
          // Re-check the line at the centre of the start bit to reject glitches
          if (cnt_reg == HALF_LAST) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            state_reg   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        ST_DATA: begin
          if (tick) begin
            cnt_reg     <= '0;
            shift_reg   <= {rx_s, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) state_reg <= ST_STOP;
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Holding register, status flags and interrupt pulse
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_data_reg   <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      int_reg       <= 1'b0;
    end else begin
      int_reg <= accept;

      if (accept) begin
        rx_data_reg <= shift_reg;
        valid_reg   <= 1'b1;
      end else if (data_rd) begin
        valid_reg <= 1'b0;
      end

      // An error raised in the cycle of a STATUS read wins over the clear
      if (frame_evt)      frame_err_reg <= 1'b1;
      else if (status_rd) frame_err_reg <= 1'b0;

      if (ovr_evt)        overrun_reg <= 1'b1;
      else if (status_rd) overrun_reg <= 1'b0;
    end
  end

  always_comb begin
    status              = '0;
    status[STAT_VALID]  = valid_reg;
    status[STAT_FERR]   = frame_err_reg;
    status[STAT_OVR]    = overrun_reg;
    status[STAT_ACTIVE] = (state_reg != ST_IDLE);
  end

  always_comb begin
    o_dat = rx_data_reg;
    if (i_adr) o_dat = {4'b0000, status};
  end

  assign o_int = int_reg;

endmodule
